// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM states, default PC constants and the
// bubble instruction word used when the IF/ID register is flushed.
package if_fetch_unit_pkg;

  // Fetch sequencer states.
  //   IDLE  : first cycle after reset, no request and ready is ignored
  //   FETCH : request pc_reg and accept the response
  //   HOLD  : a response arrived during a freeze and is parked in the skid
  //   DROP  : a branch redirected the PC while a request was outstanding
  //           (the stale response is awaited, then thrown away)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  localparam int unsigned DEFAULT_WIDTH    = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEFAULT_PC_STEP  = 4;

  // Instruction word placed in IF/ID for a bubble or flush.
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// Generic pipeline register between two stages. Flush clears the contents and
// dominates hold; hold keeps the current contents; otherwise new data loads.
module if_fetch_unit_if_id_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         hold,
  input  logic [W-1:0] inst_in,
  input  logic [W-1:0] pc_in,
  input  logic         valid_in,
  output logic [W-1:0] inst_out,
  output logic [W-1:0] pc_out,
  output logic         valid_out
);

  // Register update with priority flush > hold > load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_out  <= '0;
      pc_out    <= '0;
      valid_out <= 1'b0;
    end else if (flush) begin
      inst_out  <= '0;
      pc_out    <= '0;
      valid_out <= 1'b0;
    end else if (!hold) begin
      inst_out  <= inst_in;
      pc_out    <= pc_in;
      valid_out <= valid_in;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, variable-latency memory handshake, a one-entry
// skid buffer for responses arriving under freeze, and the IF/ID register.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int          n        = 32,
  parameter logic [n-1:0] RESET_PC = n'(DEFAULT_RESET_PC),
  parameter int          PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         branch_taken,
  input  logic [n-1:0] branch_addr,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [n-1:0] imem_rdata,
  output logic [n-1:0] Inst_out,
  output logic [n-1:0] PC_out,
  output logic         valid_out
);

  localparam logic [n-1:0] STEP = n'(PC_STEP);
  localparam logic [n-1:0] NOP  = n'(NOP_INST);

  fetch_state_t state;
  fetch_state_t next_state;

  logic [n-1:0] pc_reg;
  logic [n-1:0] pc_inc;
  logic [n-1:0] drop_addr;

  logic         skid_valid;
  logic [n-1:0] skid_inst;
  logic [n-1:0] skid_pc;

  logic         pc_load;
  logic [n-1:0] pc_next;
  logic         drop_load;
  logic         skid_fill;
  logic         skid_clear;

  logic         ifid_flush;
  logic         ifid_hold;
  logic [n-1:0] ifid_inst;
  logic [n-1:0] ifid_pc;
  logic         ifid_valid;

  assign pc_inc = pc_reg + STEP;

  // While draining a stale request the address must stay on the old PC, so
  // DROP presents its own captured address instead of pc_reg.
  assign imem_addr = (state == DROP) ? drop_addr : pc_reg;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection; a taken branch overrides freeze and ready.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        next_state = FETCH;
      end
      FETCH: begin
        if (branch_taken) begin
          next_state = imem_ready ? FETCH : DROP;
        end else if (imem_ready && freeze) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (branch_taken || !freeze) begin
          next_state = FETCH;
        end
      end
      DROP: begin
        if (!branch_taken && imem_ready) begin
          next_state = FETCH;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output and datapath control decoded from state and inputs.
  always_comb begin
    imem_req   = (state == FETCH) || (state == DROP);
    pc_load    = 1'b0;
    pc_next    = pc_reg;
    drop_load  = 1'b0;
    skid_fill  = 1'b0;
    skid_clear = 1'b0;
    ifid_flush = 1'b0;
    ifid_hold  = 1'b1;
    ifid_inst  = NOP;
    ifid_pc    = '0;
    ifid_valid = 1'b0;
    if (branch_taken) begin
      pc_load    = 1'b1;
      pc_next    = branch_addr;
      ifid_flush = 1'b1;
      skid_clear = 1'b1;
      drop_load  = (state == FETCH) && !imem_ready;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            pc_load = 1'b1;
            pc_next = pc_inc;
            if (freeze) begin
              skid_fill = 1'b1;
            end else begin
              ifid_hold  = 1'b0;
              ifid_inst  = imem_rdata;
              ifid_pc    = pc_inc;
              ifid_valid = 1'b1;
            end
          end else if (!freeze) begin
            ifid_flush = 1'b1;
          end
        end
        HOLD: begin
          if (!freeze) begin
            ifid_hold  = 1'b0;
            ifid_inst  = skid_inst;
            ifid_pc    = skid_pc;
            ifid_valid = skid_valid;
            skid_clear = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Program counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg <= RESET_PC;
    end else if (pc_load) begin
      pc_reg <= pc_next;
    end
  end

  // Address of the outstanding request being drained after a branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_addr <= RESET_PC;
    end else if (drop_load) begin
      drop_addr <= pc_reg;
    end
  end

  // One-entry skid buffer holding a response that arrived under freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_valid <= 1'b0;
      skid_inst  <= '0;
      skid_pc    <= '0;
    end else if (skid_clear) begin
      skid_valid <= 1'b0;
      skid_inst  <= '0;
      skid_pc    <= '0;
    end else if (skid_fill) begin
      skid_valid <= 1'b1;
      skid_inst  <= imem_rdata;
      skid_pc    <= pc_inc;
    end
  end

  if_fetch_unit_if_id_reg #(
    .W(n)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .flush    (ifid_flush),
    .hold     (ifid_hold),
    .inst_in  (ifid_inst),
    .pc_in    (ifid_pc),
    .valid_in (ifid_valid),
    .inst_out (Inst_out),
    .pc_out   (PC_out),
    .valid_out(valid_out)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a randomized
// stream checked against a program-order reference model.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Inst_out;
  logic [31:0] PC_out;
  logic        valid_out;

  int checks;
  int failures;

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .Inst_out    (Inst_out),
    .PC_out      (PC_out),
    .valid_out   (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: each word is its address with the top bits flipped.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hE000_0000;
  endfunction

  // Called at a falling edge: drive inputs, let one rising edge pass, and
  // return at the next falling edge where outputs are settled.
  task automatic cycle(input logic frz, input logic br, input logic [31:0] baddr,
                       input logic rdy);
    freeze       = frz;
    branch_taken = br;
    branch_addr  = baddr;
    imem_ready   = rdy;
    imem_rdata   = mem_word(imem_addr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    imem_ready   = 1'b0;
    imem_rdata   = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    imem_ready   = 1'b1;
    imem_rdata   = '0;
    #3;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0h want 0", valid_out); end
    checks++; if (Inst_out !== 32'h0) begin failures++; $display("FAIL reset_inst: got %h want 0", Inst_out); end
    checks++; if (PC_out !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want 0", PC_out); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %0h want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req: got %0h want 1", imem_req); end
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL first_valid: got %0h want 0", valid_out); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL first_addr: got %h want 0", imem_addr); end
  endtask

  // Continues straight after test_reset with a memory that never waits.
  task automatic test_zero_wait();
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL zw_valid[%0d]: got %0h want 1", k, valid_out); end
      checks++; if (PC_out !== 32'(4 * k)) begin failures++; $display("FAIL zw_pc[%0d]: got %h want %h", k, PC_out, 32'(4 * k)); end
      checks++; if (Inst_out !== mem_word(32'(4 * (k - 1)))) begin failures++; $display("FAIL zw_inst[%0d]: got %h want %h", k, Inst_out, mem_word(32'(4 * (k - 1)))); end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] exp_next;
    logic        rdy;
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    exp_next = 32'h0;
    for (int i = 0; i < 12; i++) begin
      rdy = ((i % 3) == 2);
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_next) begin failures++; $display("FAIL ws_addr[%0d]: got req=%0h addr=%h want req=1 addr=%h", i, imem_req, imem_addr, exp_next); end
      cycle(1'b0, 1'b0, 32'h0, rdy);
      if (rdy) begin
        checks++; if (valid_out !== 1'b1 || PC_out !== exp_next + 32'd4 || Inst_out !== mem_word(exp_next)) begin failures++; $display("FAIL ws_deliver[%0d]: got v=%0h pc=%h inst=%h want v=1 pc=%h inst=%h", i, valid_out, PC_out, Inst_out, exp_next + 32'd4, mem_word(exp_next)); end
        exp_next = exp_next + 32'd4;
      end else begin
        checks++; if (valid_out !== 1'b0 || Inst_out !== 32'h0) begin failures++; $display("FAIL ws_bubble[%0d]: got v=%0h inst=%h want v=0 inst=0", i, valid_out, Inst_out); end
      end
    end
  endtask

  task automatic test_freeze_arrival();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL fz_setup_addr: got %h want 10", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL fz_req[%0d]: got %0h want 0", i, imem_req); end
      checks++; if (valid_out !== 1'b1 || Inst_out !== mem_word(32'hC) || PC_out !== 32'h10) begin failures++; $display("FAIL fz_hold[%0d]: got v=%0h inst=%h pc=%h want v=1 inst=%h pc=10", i, valid_out, Inst_out, PC_out, mem_word(32'hC)); end
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (valid_out !== 1'b1 || Inst_out !== mem_word(32'h10) || PC_out !== 32'h14) begin failures++; $display("FAIL fz_release: got v=%0h inst=%h pc=%h want v=1 inst=%h pc=14", valid_out, Inst_out, PC_out, mem_word(32'h10)); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin failures++; $display("FAIL fz_next_fetch: got req=%0h addr=%h want req=1 addr=14", imem_req, imem_addr); end
  endtask

  task automatic test_branch_wait();
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (imem_addr !== 32'h20) begin failures++; $display("FAIL bw_setup_addr: got %h want 20", imem_addr); end
    cycle(1'b0, 1'b1, 32'h100, 1'b0);
    checks++; if (valid_out !== 1'b0 || Inst_out !== 32'h0 || PC_out !== 32'h0) begin failures++; $display("FAIL bw_flush: got v=%0h inst=%h pc=%h want all 0", valid_out, Inst_out, PC_out); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin failures++; $display("FAIL bw_stale_addr: got req=%0h addr=%h want req=1 addr=20", imem_req, imem_addr); end
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin failures++; $display("FAIL bw_stale_hold: got req=%0h addr=%h want req=1 addr=20", imem_req, imem_addr); end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL bw_discard: got v=%0h want 0", valid_out); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL bw_target_req: got req=%0h addr=%h want req=1 addr=100", imem_req, imem_addr); end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (valid_out !== 1'b1 || PC_out !== 32'h104 || Inst_out !== mem_word(32'h100)) begin failures++; $display("FAIL bw_target_deliver: got v=%0h pc=%h inst=%h want v=1 pc=104 inst=%h", valid_out, PC_out, Inst_out, mem_word(32'h100)); end
  endtask

  // Continues from test_branch_wait with the unit fetching 0x104.
  task automatic test_branch_freeze_ready();
    cycle(1'b1, 1'b1, 32'h200, 1'b1);
    checks++; if (valid_out !== 1'b0 || PC_out !== 32'h0) begin failures++; $display("FAIL bfr_flush: got v=%0h pc=%h want v=0 pc=0", valid_out, PC_out); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL bfr_no_hold: got req=%0h addr=%h want req=1 addr=200", imem_req, imem_addr); end
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL bfr_skid_empty: got v=%0h want 0", valid_out); end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (valid_out !== 1'b1 || PC_out !== 32'h204 || Inst_out !== mem_word(32'h200)) begin failures++; $display("FAIL bfr_deliver: got v=%0h pc=%h inst=%h want v=1 pc=204 inst=%h", valid_out, PC_out, Inst_out, mem_word(32'h200)); end
  endtask

  task automatic test_wrap();
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_target: got %h want fffffffc", imem_addr); end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (valid_out !== 1'b1 || PC_out !== 32'h0 || Inst_out !== mem_word(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_deliver: got v=%0h pc=%h inst=%h want v=1 pc=0 inst=%h", valid_out, PC_out, Inst_out, mem_word(32'hFFFF_FFFC)); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next: got %h want 0", imem_addr); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    imem_ready = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0 || Inst_out !== 32'h0 || PC_out !== 32'h0 || imem_req !== 1'b0) begin failures++; $display("FAIL ar_immediate: got v=%0h inst=%h pc=%h req=%0h want all 0", valid_out, Inst_out, PC_out, imem_req); end
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid_out !== 1'b0) begin failures++; $display("FAIL ar_first_req: got req=%0h addr=%h v=%0h want req=1 addr=0 v=0", imem_req, imem_addr, valid_out); end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (valid_out !== 1'b1 || PC_out !== 32'h4 || Inst_out !== mem_word(32'h0)) begin failures++; $display("FAIL ar_first_deliver: got v=%0h pc=%h inst=%h want v=1 pc=4 inst=%h", valid_out, PC_out, Inst_out, mem_word(32'h0)); end
  endtask

  // Random ready and freeze; the model tracks program order, the next address
  // the memory should see, and at most one fetched-but-undelivered word.
  task automatic test_random_stream();
    logic [31:0] exp_next;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        pending;
    logic [31:0] pend_inst;
    logic [31:0] pend_pc;
    logic        rdy;
    logic        frz;
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    exp_next  = 32'h0;
    exp_inst  = 32'h0;
    exp_pc    = 32'h0;
    exp_valid = 1'b0;
    pending   = 1'b0;
    pend_inst = 32'h0;
    pend_pc   = 32'h0;
    for (int i = 0; i < 300; i++) begin
      checks++; if (imem_req !== !pending || (!pending && imem_addr !== exp_next)) begin failures++; $display("FAIL rnd_req[%0d]: got req=%0h addr=%h want req=%0h addr=%h", i, imem_req, imem_addr, !pending, exp_next); end
      rdy = 1'($urandom_range(0, 1));
      frz = ($urandom_range(0, 3) == 0);
      if (pending) begin
        if (!frz) begin
          exp_inst  = pend_inst;
          exp_pc    = pend_pc;
          exp_valid = 1'b1;
          pending   = 1'b0;
        end
      end else if (rdy) begin
        if (frz) begin
          pend_inst = mem_word(exp_next);
          pend_pc   = exp_next + 32'd4;
          pending   = 1'b1;
        end else begin
          exp_inst  = mem_word(exp_next);
          exp_pc    = exp_next + 32'd4;
          exp_valid = 1'b1;
        end
        exp_next = exp_next + 32'd4;
      end else if (!frz) begin
        exp_inst  = 32'h0;
        exp_valid = 1'b0;
      end
      cycle(frz, 1'b0, 32'h0, rdy);
      checks++; if (valid_out !== exp_valid || Inst_out !== exp_inst || (exp_valid && PC_out !== exp_pc)) begin failures++; $display("FAIL rnd_ifid[%0d]: got v=%0h inst=%h pc=%h want v=%0h inst=%h pc=%h", i, valid_out, Inst_out, PC_out, exp_valid, exp_inst, exp_pc); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_freeze_arrival();
    test_branch_wait();
    test_branch_freeze_ready();
    test_wrap();
    test_async_reset();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage with its IF/ID pipeline register. It is the producer side of the decode stage's Inst/PC inputs.
- Keeps the PC and fetches from an instruction memory through a req/ready handshake with variable latency.
- Presents Inst_out/PC_out/valid_out to decode. Honors the decode-stage Hazard as freeze, and honors branch flush from the execute stage.
- Has a one-entry skid buffer, so a response that arrives during a freeze is not lost.

Parameters:
- n, 32, instruction and address width.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  clock; everything updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- freeze  input  1  decode hazard; holds the IF/ID register and stops PC advance.
- branch_taken  input  1  execute-stage branch; redirects the PC and flushes.
- branch_addr  input  n  branch target.
- imem_req  output  1  fetch request, combinational from state.
- imem_addr  output  n  fetch address (= pc_reg).
- imem_ready  input  1  memory response valid this cycle; rdata is sampled now.
- imem_rdata  input  n  fetched instruction.
- Inst_out  output  n  IF/ID instruction.
- PC_out  output  n  IF/ID PC, equal to fetched address + PC_STEP.
- valid_out  output  1  IF/ID holds a real instruction; 0 means bubble.

Behaviour:
- Reset (rst=0, async):
  - pc_reg=RESET_PC, state=IDLE, skid empty.
  - Inst_out=0, PC_out=0, valid_out=0, imem_req=0.
- States: IDLE, FETCH, HOLD, DROP.
- imem_req=1 only in FETCH and DROP. imem_addr=pc_reg.
- Address stability: while imem_req=1 and imem_ready=0, imem_addr must not change.
- IDLE → FETCH unconditionally on the next edge.
- FETCH, imem_ready=1, no branch:
  - pc_reg += PC_STEP.
  - If freeze=0: Inst_out=rdata, PC_out=pc_reg+PC_STEP, valid_out=1; stay in FETCH.
  - If freeze=1: rdata and PC+PC_STEP go to the skid buffer; IF/ID is unchanged; go to HOLD.
- FETCH, imem_ready=0:
  - If freeze=0: valid_out←0, Inst_out←0 (bubble).
  - If freeze=1: IF/ID is held.
- HOLD:
  - imem_req=0.
  - When freeze=0: IF/ID←skid, valid_out←1, skid emptied; go to FETCH.
- DROP:
  - Keeps requesting the stale address until imem_ready, then discards the data.
  - On that ready cycle, go to FETCH. pc_reg already holds the target.
- branch_taken=1 has the highest priority over freeze, ready, and state:
  - pc_reg←branch_addr.
  - IF/ID flushed: valid_out=0, Inst_out=0, PC_out=0.
  - Skid emptied.
  - Next state depends on where the branch arrives:
    - FETCH with imem_ready=0: go to DROP, but imem_addr stays at the old PC. The DROP address register is separate from pc_reg.
    - FETCH with imem_ready=1: data discarded; stay in FETCH at the target.
    - HOLD or IDLE: go to FETCH.
    - DROP: target updated; stay in DROP.
- Throughput: with a zero-wait memory (ready the same cycle as req), one instruction per cycle. Latency from req to IF/ID is 1 edge.
- Arithmetic: PC increment wraps modulo 2^n; no overflow detection.
- Reset mid-operation: immediate return to reset values. Any outstanding memory response after reset is ignored, because IDLE does not sample ready.

Decomposition:
- Shared pipeline package holds:
  - state enum {IDLE, FETCH, HOLD, DROP}.
  - PC_STEP and RESET_PC defaults.
  - NOP/bubble instruction constant (0).
- One natural sub-module: if_id_reg. It is the IF/ID register with freeze (hold) and flush (clear) inputs, flush dominating. It is reusable for the later pipeline registers.
- The FSM, PC, and skid buffer stay in if_fetch_unit.

Test Plan:
- Zero-wait stream: after reset release, ready=1 always, rdata=addr ^ 0xE000_0000 → valid_out=1 from the 2nd edge. PC_out=4,8,12,… and Inst_out matches addresses 0,4,8.
- Wait states: ready asserted every 3rd cycle → imem_addr stable across waits, valid_out=0 on non-ready edges, no PC skip or duplicate.
- Freeze with arrival: freeze=1 for 3 cycles while ready=1 at addr 0x10 → IF/ID holds the previous instruction, state HOLD, imem_req=0. On freeze release, Inst_out=mem[0x10] and PC_out=0x14; the next fetch is 0x14.
- Branch during wait: branch_taken=1, branch_addr=0x100 while addr 0x20 is outstanding → valid_out=0. The 0x20 response is discarded, the next request is addr 0x100, and then PC_out=0x104.
- Branch + freeze + ready in the same cycle → flush wins. pc=branch_addr, valid_out=0, skid empty, no HOLD.
- Async reset asserted mid-wait (between edges) → outputs zero immediately. After release, the first request goes to RESET_PC one cycle later, and the late ready from the stale request is ignored.
